// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch/data) arbiter onto a single registered memory port
// Data wins by default; fetch is forced through after two consecutive data wins over a waiting fetch.
module mem_port_arbiter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ireq_i,
    input  logic [15:0] iaddr_i,
    input  logic        dreq_i,
    input  logic        dwrite_i,
    input  logic [15:0] daddr_i,
    input  logic [15:0] dwdata_i,
    input  logic [15:0] mem_rdata_i,
    output logic        ignt_o,
    output logic        dgnt_o,
    output logic        ivalid_o,
    output logic        dvalid_o,
    output logic [15:0] rdata_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IACC = 2'd1,
        S_DACC = 2'd2,
        S_WAIT = 2'd3
    } state_e;

    state_e      state_q;
    logic [1:0]  starve_q;
    logic [1:0]  starve_d;
    logic        ignt_q;
    logic        dgnt_q;
    logic        ivalid_q;
    logic        dvalid_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        busy_q;

    logic arb;
    logic d_win;
    logic i_win;

    always_comb begin
        arb      = (state_q == S_IDLE) || (state_q == S_WAIT);
        d_win    = arb && dreq_i && ((starve_q < 2'd2) || !ireq_i);
        i_win    = arb && ireq_i && !d_win;
        starve_d = starve_q;
        if (arb) begin
            if (d_win && ireq_i) begin
                starve_d = (starve_q == 2'd2) ? 2'd2 : starve_q + 2'd1;
            end else begin
                starve_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            starve_q    <= 2'd0;
            ignt_q      <= 1'b0;
            dgnt_q      <= 1'b0;
            ivalid_q    <= 1'b0;
            dvalid_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            ignt_q      <= 1'b0;
            dgnt_q      <= 1'b0;
            ivalid_q    <= (state_q == S_IACC);
            dvalid_q    <= (state_q == S_DACC);
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (i_win) begin
                state_q    <= S_IACC;
                ignt_q     <= 1'b1;
                mem_read_q <= 1'b1;
                mem_addr_q <= iaddr_i;
                busy_q     <= 1'b1;
            end else if (d_win) begin
                state_q     <= S_DACC;
                dgnt_q      <= 1'b1;
                mem_read_q  <= !dwrite_i;
                mem_write_q <= dwrite_i;
                mem_addr_q  <= daddr_i;
                mem_wdata_q <= dwdata_i;
                busy_q      <= 1'b1;
            end else if (arb) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                // Access cycles always fall through to WAIT, where the next winner is picked.
                state_q <= S_WAIT;
                busy_q  <= 1'b1;
            end
        end
    end

    assign ignt_o      = ignt_q;
    assign dgnt_o      = dgnt_q;
    assign ivalid_o    = ivalid_q;
    assign dvalid_o    = dvalid_q;
    assign rdata_o     = mem_rdata_i;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq;
    logic [15:0] iaddr;
    logic        dreq;
    logic        dwrite;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    logic [15:0] mem_rdata;
    logic        ignt, dgnt, ivalid, dvalid;
    logic [15:0] rdata, mem_addr, mem_wdata;
    logic        mem_read, mem_write, busy;

    logic        rand_phase = 1'b0;
    logic [15:0] mem_fixed = 16'h0000;
    logic [15:0] mem_model_q = 16'h0000;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .ireq_i      (ireq),
        .iaddr_i     (iaddr),
        .dreq_i      (dreq),
        .dwrite_i    (dwrite),
        .daddr_i     (daddr),
        .dwdata_i    (dwdata),
        .mem_rdata_i (mem_rdata),
        .ignt_o      (ignt),
        .dgnt_o      (dgnt),
        .ivalid_o    (ivalid),
        .dvalid_o    (dvalid),
        .rdata_o     (rdata),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .busy_o      (busy)
    );

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Simple memory: read data appears the cycle after a read strobe.
    always @(posedge clk) if (mem_read) mem_model_q <= memf(mem_addr);
    assign mem_rdata = rand_phase ? mem_model_q : mem_fixed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic ir, input logic [15:0] ia, input logic dr,
                         input logic dw, input logic [15:0] da, input logic [15:0] dd);
        ireq = ir; iaddr = ia; dreq = dr; dwrite = dw; daddr = da; dwdata = dd;
    endtask

    initial begin
        string seq;
        int    gk;
        int    exp_st [6] = '{1, 2, 0, 1, 2, 0};
        int    dgnt_seen;
        // reference model state for the random phase
        int          next_arb, vedge, starve;
        logic        vkind_d, vread;
        logic [15:0] e_addr, e_wdata, v_addr;
        logic        x_gi, x_gd, x_vi, x_vd, x_rd, x_wr, x_busy;
        logic        dwin, iwin, rst;

        reset = 1'b1;
        drive(1, 16'h1111, 1, 1, 16'h2222, 16'h3333);
        step(); step();
        chk("rst_ignt", ignt, 0);      chk("rst_dgnt", dgnt, 0);
        chk("rst_valid", {ivalid, dvalid}, 0);
        chk("rst_strobe", {mem_read, mem_write}, 0);
        chk("rst_addr", mem_addr, 0);  chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();

        // single load
        mem_fixed = 16'hBEEF;
        drive(0, 0, 1, 0, 16'h0040, 0);
        step();
        chk("ld_dgnt", dgnt, 1);       chk("ld_ignt", ignt, 0);
        chk("ld_read", mem_read, 1);   chk("ld_write", mem_write, 0);
        chk("ld_addr", mem_addr, 16'h0040); chk("ld_busy", busy, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("ld_dvalid", dvalid, 1);   chk("ld_rdata", rdata, 16'hBEEF);
        chk("ld_read_off", mem_read, 0); chk("ld_dgnt_off", dgnt, 0);
        step();
        chk("ld_idle_busy", busy, 0);  chk("ld_dvalid_off", dvalid, 0);

        // single store
        drive(0, 0, 1, 1, 16'h0010, 16'h1234);
        step();
        chk("st_dgnt", dgnt, 1);       chk("st_write", mem_write, 1);
        chk("st_read", mem_read, 0);   chk("st_wdata", mem_wdata, 16'h1234);
        chk("st_addr", mem_addr, 16'h0010);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("st_dvalid", dvalid, 1);   chk("st_write_off", mem_write, 0);
        step();

        // both requests held: D, D, I repeating
        drive(1, 16'h0100, 1, 0, 16'h0200, 0);
        seq = "";
        gk = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("arb_one_gnt", ignt & dgnt, 0);
            chk("arb_strobe_excl", mem_read & mem_write, 0);
            if (dgnt) seq = {seq, "D"};
            if (ignt) seq = {seq, "I"};
            if ((ignt || dgnt) && gk < 6) begin
                chk($sformatf("arb_starve_%0d", gk), dut.starve_q, exp_st[gk]);
                gk++;
            end
        end
        total++;
        assert (seq == "DDIDDI") else begin
            bad++;
            $error("FAIL arb_order observed=%s expected=DDIDDI", seq);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("arb_idle_busy", busy, 0);

        // fetch only
        dgnt_seen = 0;
        drive(1, 16'h0000, 0, 0, 0, 0);
        step();
        chk("if_gnt0", ignt, 1);       chk("if_addr0", mem_addr, 16'h0000);
        dgnt_seen += int'(dgnt);
        iaddr = 16'h0002;
        step();
        chk("if_valid0", ivalid, 1);   chk("if_gnt_gap", ignt, 0);
        dgnt_seen += int'(dgnt);
        step();
        chk("if_gnt1", ignt, 1);       chk("if_addr1", mem_addr, 16'h0002);
        dgnt_seen += int'(dgnt);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("if_valid1", ivalid, 1);
        dgnt_seen += int'(dgnt);
        chk("if_no_dgnt", dgnt_seen, 0);
        step();

        // reset during the data grant cycle aborts the access
        drive(0, 0, 1, 0, 16'h0080, 0);
        step();
        chk("ab_dgnt", dgnt, 1);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("ab_dvalid", dvalid, 0);   chk("ab_busy", busy, 0);
        chk("ab_strobe", {mem_read, mem_write}, 0);
        chk("ab_addr", mem_addr, 0);   chk("ab_gnt", {ignt, dgnt, ivalid}, 0);
        reset = 1'b0;
        step();
        chk("ab_no_late_valid", dvalid, 0);

        // randomized traffic against a transaction-level model
        rand_phase = 1'b1;
        next_arb = 0; vedge = -1; starve = 0; vkind_d = 0; vread = 0;
        e_addr = 0; e_wdata = 0; v_addr = 0;
        x_gi = 0; x_gd = 0; x_vi = 0; x_vd = 0; x_rd = 0; x_wr = 0; x_busy = 0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) begin
                chk("r_ignt", ignt, x_gi);       chk("r_dgnt", dgnt, x_gd);
                chk("r_ivalid", ivalid, x_vi);   chk("r_dvalid", dvalid, x_vd);
                chk("r_read", mem_read, x_rd);   chk("r_write", mem_write, x_wr);
                chk("r_addr", mem_addr, e_addr); chk("r_wdata", mem_wdata, e_wdata);
                chk("r_busy", busy, x_busy);
                if ((x_vi || x_vd) && vread) chk("r_rdata", rdata, memf(v_addr));
            end
            rst = (c == 0) || ($urandom_range(0, 39) == 0);
            reset = rst;
            drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
                  1'($urandom), 16'($urandom), 16'($urandom));
            x_gi = 0; x_gd = 0; x_rd = 0; x_wr = 0;
            if (rst) begin
                x_vi = 0; x_vd = 0; x_busy = 0;
                starve = 0; next_arb = c + 1; vedge = -1;
                e_addr = 0; e_wdata = 0;
            end else begin
                x_vi = (vedge == c) && !vkind_d;
                x_vd = (vedge == c) && vkind_d;
                if (x_vi || x_vd) vread = vread; // keep the read flag of the finishing access
                if (c >= next_arb) begin
                    dwin = dreq && (starve < 2 || !ireq);
                    iwin = !dwin && ireq;
                    if (dwin) begin
                        x_gd = 1; x_rd = !dwrite; x_wr = dwrite;
                        e_addr = daddr; e_wdata = dwdata;
                        starve = ireq ? ((starve + 1 > 2) ? 2 : starve + 1) : 0;
                        next_arb = c + 2; x_busy = 1;
                    end else if (iwin) begin
                        x_gi = 1; x_rd = 1; e_addr = iaddr;
                        starve = 0; next_arb = c + 2; x_busy = 1;
                    end else begin
                        starve = 0; x_busy = 0;
                    end
                end else begin
                    x_busy = 1;
                end
            end
            step();
            // the access started at this edge completes at the following one
            if (x_vi || x_vd) vedge = -1;
            if (x_gi || x_gd) begin
                vedge = c + 1; vkind_d = x_gd; vread = x_rd; v_addr = e_addr;
            end
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 CLK  in  1  system clock; all state changes on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 IReq  in  1  instruction-fetch request; held high until IGnt seen.
REQ-004 IAddr  in  16  fetch address; stable while IReq high.
REQ-005 DReq  in  1  data-access request; held high until DGnt seen.
REQ-006 DWrite  in  1  1 = store, 0 = load; stable while DReq high.
REQ-007 DAddr  in  16  data address; stable while DReq high.
REQ-008 DWData  in  16  store data; stable while DReq high.
REQ-009 MemRData  in  16  memory read data, valid the cycle after MemRead.
REQ-010 IGnt  out  1  one-cycle pulse: fetch accepted, memory cycle in progress.
REQ-011 DGnt  out  1  one-cycle pulse: data access accepted, memory cycle in progress.
REQ-012 IValid  out  1  one-cycle pulse: RData holds fetched word.
REQ-013 DValid  out  1  one-cycle pulse: load data on RData, or store complete.
REQ-014 RData  out  16  MemRData passed through; only meaningful with IValid/DValid.
REQ-015 MemAddr  out  16  memory address, registered.
REQ-016 MemWData  out  16  memory write data, registered.
REQ-017 MemRead  out  1  memory read strobe, registered.
REQ-018 MemWrite  out  1  memory write strobe, registered.
REQ-019 Busy  out  1  high in every state except IDLE.

Function
REQ-020 FSM SHALL have states IDLE, IACC, DACC, WAIT.
REQ-021 Arbitration SHALL occur in IDLE and WAIT; winner's address/data/type latched into MemAddr/MemWData/MemRead/MemWrite on the same edge.
REQ-022 Winner SHALL be D if DReq and StarveCnt<2; else I if IReq; else D if DReq; else none.
REQ-023 2-bit StarveCnt SHALL increment (saturating at 2) when D wins while IReq=1, clear when I wins or IReq=0.
REQ-024 I wins -> next state IACC; D wins -> DACC; none -> IDLE.
REQ-025 IACC: IGnt=1, MemRead=1, MemWrite=0, MemAddr=latched IAddr; next state WAIT.
REQ-026 DACC: DGnt=1, MemRead=~DWrite, MemWrite=DWrite, MemAddr=latched DAddr, MemWData=latched DWData; next state WAIT.
REQ-027 WAIT: IValid=1 if previous state IACC, DValid=1 if previous state DACC; MemRead=MemWrite=0 unless a new winner is latched per REQ-021.
REQ-028 Latency SHALL be: request sampled at edge T, Gnt and strobe during cycle T+1, Valid during cycle T+2.
REQ-029 Back-to-back throughput SHALL be one access per 2 cycles (WAIT->ACC->WAIT).
REQ-030 Exactly one of IGnt/DGnt at most per cycle; exactly one of IValid/DValid at most per cycle; MemRead and MemWrite never both 1.
REQ-031 Request dropped before grant SHALL be ignored without error; request held after grant SHALL be treated as a new request.

Reset
REQ-032 Reset high at an edge SHALL force state IDLE, StarveCnt=0, all outputs 0 including MemAddr/MemWData.
REQ-033 Reset during IACC/DACC/WAIT SHALL abort the access: no Valid pulse, no further Mem strobe; Reset overrides all requests.

Verification
REQ-034 Single load: DReq=1,DWrite=0,DAddr=0x0040, MemRData=0xBEEF -> DGnt+MemRead, MemAddr=0x0040 at T+1; DValid, RData=0xBEEF at T+2.
REQ-035 Single store: DReq=1,DWrite=1,DAddr=0x0010,DWData=0x1234 -> T+1 MemWrite=1,MemRead=0,MemWData=0x1234; T+2 DValid=1.
REQ-036 Simultaneous IReq/DReq from IDLE, held -> grant order D, D, I, D, D, I; StarveCnt 1,2,0.
REQ-037 Fetch only, IReq held, IAddr=0x0000 then 0x0002 -> IGnt every 2nd cycle, IValid in between, DGnt never.
REQ-038 Reset asserted in cycle of DGnt -> next cycle all outputs 0, no DValid, Busy=0.
